// File: rtl/sign_conv_serial.sv
// Digit-serial converter between two's complement and sign-magnitude, plus NEG/ABS.
// Processes W bits per clock through a carried ripple chain over D = N/W cycles.
module sign_conv_serial #(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(D - 1);
    localparam logic [N-1:0]  MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    x_q;
    logic [N-1:0]    res_q;
    logic [CW-1:0]   cnt_q;
    logic            g_q;
    logic            carry_q;
    logic            ovf_q;
    logic            tc_q;
    logic            sign_q;

    logic [N-1:0]    x_acc;
    logic            g_acc;
    logic            ovf_acc;
    logic [IW-1:0]   idx;
    logic [W-1:0]    xdig;
    logic [W:0]      sum;
    logic [N-1:0]    res_d;

    // Operand decode at accept: SM2TC strips the sign bit before the conditional negate.
    always_comb begin
        x_acc   = in_data;
        g_acc   = in_data[N-1];
        ovf_acc = (in_data == MINV);
        case (in_mode)
            2'b01: begin
                x_acc   = {1'b0, in_data[N-2:0]};
                ovf_acc = 1'b0;
            end
            2'b10:   g_acc = 1'b1;
            default: ;
        endcase
    end

    // One digit of the conditional invert-and-increment ripple chain.
    always_comb begin
        idx   = IW'(int'(cnt_q) * W);
        xdig  = x_q[idx +: W];
        sum   = {1'b0, xdig ^ {W{g_q}}} + {{W{1'b0}}, carry_q};
        res_d = res_q;
        res_d[idx +: W] = sum[W-1:0];
        if (tc_q && cnt_q == LAST) begin
            res_d[N-1] = sign_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            tc_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_acc;
                        g_q     <= g_acc;
                        carry_q <= g_acc;
                        ovf_q   <= ovf_acc;
                        tc_q    <= (in_mode == 2'b00);
                        sign_q  <= in_data[N-1];
                        cnt_q   <= '0;
                        res_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum[W];
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sign_conv_serial.sv
// Directed bench for sign_conv_serial: three instances (8/1, 8/4, 16/4) with
// hand-computed expected results, latencies, backpressure and async reset.
module tb_sign_conv_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b0;
    logic        vld [3];
    logic        ir [3];
    logic        ov [3];
    logic        of [3];
    logic [15:0] od [3];
    logic [7:0]  d0, d1;
    logic [15:0] d2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    sign_conv_serial #(.N(8), .W(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]),
        .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(d0), .out_ovf(of[0]));
    sign_conv_serial #(.N(8), .W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]),
        .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(d1), .out_ovf(of[1]));
    sign_conv_serial #(.N(16), .W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]),
        .in_data(in_data), .in_mode(in_mode), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(d2), .out_ovf(of[2]));

    assign od[0] = {8'h00, d0};
    assign od[1] = {8'h00, d1};
    assign od[2] = d2;

    // Drives one transfer on instance u, waits (bounded) for out_valid, then
    // completes the output handshake. cyc = -1 on timeout.
    task automatic do_op(input int u, input logic [1:0] m, input logic [15:0] d,
                         output logic [15:0] res, output logic ovf, output int cyc,
                         output logic rdy_bad);
        res = '0; ovf = 1'b0; cyc = -1; rdy_bad = 1'b0;
        in_mode = m; in_data = d; vld[u] = 1'b1;
        @(posedge clk); #1;
        vld[u] = 1'b0;
        for (int i = 1; i <= 40 && cyc < 0; i++) begin
            if (ir[u]) rdy_bad = 1'b1;
            @(posedge clk); #1;
            if (ov[u]) begin
                cyc = i; res = od[u]; ovf = of[u];
            end
        end
        if (ir[u]) rdy_bad = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_data = 16'h0003; in_mode = 2'b10;
        vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (ir[0] !== 1'b1) begin nmis++; $display("FAIL reset_in_ready got %b want 1", ir[0]); end
        nvec++; if (ov[0] !== 1'b0) begin nmis++; $display("FAIL reset_out_valid got %b want 0", ov[0]); end
        nvec++; if (od[0] !== 16'h0000 || of[0] !== 1'b0) begin nmis++; $display("FAIL reset_outputs got %h/%b want 0000/0", od[0], of[0]); end
        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++; if (ir[0] !== 1'b1) begin nmis++; $display("FAIL reset_no_transfer in_ready got %b want 1", ir[0]); end
    endtask

    task automatic test_tc2sm;
        logic [15:0] r; logic o; int c; logic rb;
        do_op(0, 2'b00, 16'h00FB, r, o, c, rb);
        nvec++; if (r !== 16'h0085 || o !== 1'b0) begin nmis++; $display("FAIL tc2sm_fb got %h/%b want 0085/0", r, o); end
        nvec++; if (c !== 8) begin nmis++; $display("FAIL tc2sm_latency got %0d want 8", c); end
        nvec++; if (rb !== 1'b0) begin nmis++; $display("FAIL tc2sm_in_ready_busy got %b want 0", rb); end
        do_op(0, 2'b00, 16'h0080, r, o, c, rb);
        nvec++; if (r !== 16'h0080 || o !== 1'b1) begin nmis++; $display("FAIL tc2sm_80 got %h/%b want 0080/1", r, o); end
    endtask

    task automatic test_sm2tc;
        logic [15:0] r; logic o; int c; logic rb;
        do_op(0, 2'b01, 16'h0085, r, o, c, rb);
        nvec++; if (r !== 16'h00FB || o !== 1'b0) begin nmis++; $display("FAIL sm2tc_85 got %h/%b want 00fb/0", r, o); end
        do_op(0, 2'b01, 16'h0080, r, o, c, rb);
        nvec++; if (r !== 16'h0000 || o !== 1'b0) begin nmis++; $display("FAIL sm2tc_neg0 got %h/%b want 0000/0", r, o); end
        do_op(0, 2'b01, 16'h0005, r, o, c, rb);
        nvec++; if (r !== 16'h0005 || o !== 1'b0) begin nmis++; $display("FAIL sm2tc_05 got %h/%b want 0005/0", r, o); end
    endtask

    task automatic test_neg;
        logic [15:0] r; logic o; int c; logic rb;
        do_op(0, 2'b10, 16'h0001, r, o, c, rb);
        nvec++; if (r !== 16'h00FF || o !== 1'b0) begin nmis++; $display("FAIL neg_01 got %h/%b want 00ff/0", r, o); end
        do_op(0, 2'b10, 16'h0080, r, o, c, rb);
        nvec++; if (r !== 16'h0080 || o !== 1'b1) begin nmis++; $display("FAIL neg_80 got %h/%b want 0080/1", r, o); end
        do_op(0, 2'b10, 16'h0000, r, o, c, rb);
        nvec++; if (r !== 16'h0000 || o !== 1'b0) begin nmis++; $display("FAIL neg_00 got %h/%b want 0000/0", r, o); end
    endtask

    task automatic test_abs_wide;
        logic [15:0] r; logic o; int c; logic rb;
        do_op(1, 2'b11, 16'h009C, r, o, c, rb);
        nvec++; if (r !== 16'h0064 || o !== 1'b0) begin nmis++; $display("FAIL abs_w4_9c got %h/%b want 0064/0", r, o); end
        nvec++; if (c !== 2) begin nmis++; $display("FAIL abs_w4_latency got %0d want 2", c); end
        do_op(1, 2'b11, 16'h007F, r, o, c, rb);
        nvec++; if (r !== 16'h007F || o !== 1'b0) begin nmis++; $display("FAIL abs_w4_7f got %h/%b want 007f/0", r, o); end
        do_op(2, 2'b11, 16'h8000, r, o, c, rb);
        nvec++; if (r !== 16'h8000 || o !== 1'b1) begin nmis++; $display("FAIL abs_n16_8000 got %h/%b want 8000/1", r, o); end
        nvec++; if (c !== 4) begin nmis++; $display("FAIL abs_n16_latency got %0d want 4", c); end
    endtask

    task automatic test_backpressure;
        int c;
        logic held_bad;
        in_mode = 2'b11; in_data = 16'h00FF; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        c = -1;
        for (int i = 1; i <= 40 && c < 0; i++) begin
            @(posedge clk); #1;
            if (ov[0]) c = i;
        end
        nvec++; if (c !== 8) begin nmis++; $display("FAIL bp_latency got %0d want 8", c); end
        // Upstream presents the next operand while the result is stalled.
        in_mode = 2'b10; in_data = 16'h0001; vld[0] = 1'b1;
        held_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b1 || od[0] !== 16'h0001 || ir[0] !== 1'b0) held_bad = 1'b1;
        end
        nvec++; if (held_bad !== 1'b0 || od[0] !== 16'h0001) begin nmis++; $display("FAIL bp_hold data %h valid %b ready %b want 0001/1/0", od[0], ov[0], ir[0]); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nvec++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin nmis++; $display("FAIL bp_after_handshake ready %b valid %b want 1/0", ir[0], ov[0]); end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        nvec++; if (ir[0] !== 1'b0) begin nmis++; $display("FAIL b2b_accept in_ready got %b want 0", ir[0]); end
        c = -1;
        for (int i = 1; i <= 40 && c < 0; i++) begin
            @(posedge clk); #1;
            if (ov[0]) c = i;
        end
        nvec++; if (c !== 8 || od[0] !== 16'h00FF || of[0] !== 1'b0) begin nmis++; $display("FAIL b2b_result got %h/%b in %0d want 00ff/0 in 8", od[0], of[0], c); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] r; logic o; int c; logic rb;
        in_mode = 2'b10; in_data = 16'h0003; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin nmis++; $display("FAIL midrun_reset ready %b valid %b want 1/0", ir[0], ov[0]); end
        nvec++; if (od[0] !== 16'h0000) begin nmis++; $display("FAIL midrun_reset_data got %h want 0000", od[0]); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 2'b10, 16'h0003, r, o, c, rb);
        nvec++; if (r !== 16'h00FD || o !== 1'b0) begin nmis++; $display("FAIL post_reset_neg got %h/%b want 00fd/0", r, o); end
        nvec++; if (c !== 8) begin nmis++; $display("FAIL post_reset_latency got %0d want 8", c); end
    endtask

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
        test_reset();
        test_tc2sm();
        test_sm2tc();
        test_neg();
        test_abs_wide();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
